// File: rtl/msf_pkg.sv
// Shared constants, types and field helpers for the MSF time-code encoder and decoder.
// The A/B bit layout is described once here so both directions agree on it.
package msf_pkg;

   localparam int unsigned MSF_SLOTS = 10;
   localparam int unsigned MSF_SECS  = 60;

   localparam logic [7:0] MSF_MARKER_A     = 8'b0111_1110;
   localparam logic [5:0] MSF_MARKER_START = 6'd52;
   localparam logic [3:0] MSF_MARKER_LEN   = 4'd8;

   localparam logic [5:0] YEAR_START  = 6'd17;
   localparam logic [3:0] YEAR_LEN    = 4'd8;
   localparam logic [5:0] MONTH_START = 6'd25;
   localparam logic [3:0] MONTH_LEN   = 4'd5;
   localparam logic [5:0] DAY_START   = 6'd30;
   localparam logic [3:0] DAY_LEN     = 4'd6;
   localparam logic [5:0] DOW_START   = 6'd36;
   localparam logic [3:0] DOW_LEN     = 4'd3;
   localparam logic [5:0] HOUR_START  = 6'd39;
   localparam logic [3:0] HOUR_LEN    = 4'd6;
   localparam logic [5:0] MIN_START   = 6'd45;
   localparam logic [3:0] MIN_LEN     = 4'd7;

   localparam logic [5:0] B_BST_WARN = 6'd53;
   localparam logic [5:0] B_PAR_YEAR = 6'd54;
   localparam logic [5:0] B_PAR_DATE = 6'd55;
   localparam logic [5:0] B_PAR_DOW  = 6'd56;
   localparam logic [5:0] B_PAR_TIME = 6'd57;
   localparam logic [5:0] B_BST      = 6'd58;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } msf_state_e;

   typedef struct packed {
      logic [7:0] year;
      logic [4:0] month;
      logic [5:0] day;
      logic [2:0] dow;
      logic [5:0] hour;
      logic [6:0] minute;
      logic       bst;
      logic       bst_warn;
   } msf_snapshot_t;

   function automatic logic in_field(input logic [5:0] sec, input logic [5:0] start,
                                     input logic [3:0] len);
      return (sec >= start) && ((sec - start) < {2'b00, len});
   endfunction

   // Fields go out MSB first, so the first second of a field carries bit len-1.
   function automatic logic field_bit(input logic [7:0] value, input logic [5:0] sec,
                                      input logic [5:0] start, input logic [3:0] len);
      return value[3'(len - 4'd1 - 4'(sec - start))];
   endfunction

endpackage

// File: rtl/msf_frame_bits.sv
// Combinational map from (second, snapshot) to the MSF A and B data bits.
// Parity bits are odd parity, i.e. the inverted XOR reduction of the covered field bits.
module msf_frame_bits
   import msf_pkg::*;
(
   input  logic [5:0]    second,
   input  msf_snapshot_t snap,
   output logic          a_bit,
   output logic          b_bit
);

   logic par_year;
   logic par_date;
   logic par_dow;
   logic par_time;

   assign par_year = ~^snap.year;
   assign par_date = ~^{snap.month, snap.day};
   assign par_dow  = ~^snap.dow;
   assign par_time = ~^{snap.hour, snap.minute};

   always_comb begin
      a_bit = 1'b0;
      if (in_field(second, YEAR_START, YEAR_LEN))
         a_bit = field_bit(snap.year, second, YEAR_START, YEAR_LEN);
      else if (in_field(second, MONTH_START, MONTH_LEN))
         a_bit = field_bit({3'b000, snap.month}, second, MONTH_START, MONTH_LEN);
      else if (in_field(second, DAY_START, DAY_LEN))
         a_bit = field_bit({2'b00, snap.day}, second, DAY_START, DAY_LEN);
      else if (in_field(second, DOW_START, DOW_LEN))
         a_bit = field_bit({5'b00000, snap.dow}, second, DOW_START, DOW_LEN);
      else if (in_field(second, HOUR_START, HOUR_LEN))
         a_bit = field_bit({2'b00, snap.hour}, second, HOUR_START, HOUR_LEN);
      else if (in_field(second, MIN_START, MIN_LEN))
         a_bit = field_bit({1'b0, snap.minute}, second, MIN_START, MIN_LEN);
      else if (in_field(second, MSF_MARKER_START, MSF_MARKER_LEN))
         a_bit = field_bit(MSF_MARKER_A, second, MSF_MARKER_START, MSF_MARKER_LEN);

      // DUT1 is not transmitted, so B stays 0 outside the flag/parity seconds.
      case (second)
         B_BST_WARN: b_bit = snap.bst_warn;
         B_PAR_YEAR: b_bit = par_year;
         B_PAR_DATE: b_bit = par_date;
         B_PAR_DOW:  b_bit = par_dow;
         B_PAR_TIME: b_bit = par_time;
         B_BST:      b_bit = snap.bst;
         default:    b_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/msf_frame_encoder.sv
// MSF 60 s frame generator: divides tick_i into 100 ms slots and emits the carrier envelope.
// The date/time snapshot is captured on entry to second 0 slot 0 and held for the whole frame.
module msf_frame_encoder
   import msf_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       enable_i,
   input  logic [7:0] year_i,
   input  logic [4:0] month_i,
   input  logic [5:0] day_i,
   input  logic [2:0] dow_i,
   input  logic [5:0] hour_i,
   input  logic [6:0] minute_i,
   input  logic       bst_i,
   input  logic       bst_warn_i,
   output logic       carrier_o,
   output logic [5:0] second_o,
   output logic       frame_start_o
);

   msf_state_e    state_reg;
   logic [7:0]    divider_reg;
   logic [3:0]    slot_reg;
   logic [5:0]    second_reg;
   msf_snapshot_t snapshot_reg;
   logic          carrier_reg;
   logic          frame_start_reg;

   logic          strobe;
   logic [3:0]    slot_next;
   logic [5:0]    second_next;
   logic          carrier_next;
   logic          a_bit;
   logic          b_bit;

   assign strobe = tick_i && (divider_reg == 8'(TICK_DIV - 1));

   // From IDLE the first strobe lands on second 0 slot 0.
   always_comb begin
      slot_next   = 4'd0;
      second_next = 6'd0;
      if (state_reg == ST_RUN) begin
         if (slot_reg == 4'(MSF_SLOTS - 1)) begin
            slot_next   = 4'd0;
            second_next = (second_reg == 6'(MSF_SECS - 1)) ? 6'd0 : second_reg + 6'd1;
         end else begin
            slot_next   = slot_reg + 4'd1;
            second_next = second_reg;
         end
      end
   end

   // The old snapshot is fine here: a fresh one only matters from second 1 on.
   msf_frame_bits u_bits (
      .second (second_next),
      .snap   (snapshot_reg),
      .a_bit  (a_bit),
      .b_bit  (b_bit)
   );

   always_comb begin
      carrier_next = 1'b1;
      if (second_next == 6'd0) begin
         carrier_next = (slot_next >= 4'd5);
      end else begin
         case (slot_next)
            4'd0:    carrier_next = 1'b0;
            4'd1:    carrier_next = ~a_bit;
            4'd2:    carrier_next = ~b_bit;
            default: carrier_next = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg       <= ST_IDLE;
         divider_reg     <= 8'd0;
         slot_reg        <= 4'd0;
         second_reg      <= 6'd0;
         snapshot_reg    <= '0;
         carrier_reg     <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= 1'b0;
         // Dropping enable aborts the frame and outranks a coincident strobe.
         if (!enable_i) begin
            state_reg   <= ST_IDLE;
            divider_reg <= 8'd0;
            slot_reg    <= 4'd0;
            second_reg  <= 6'd0;
            carrier_reg <= 1'b1;
         end else if (tick_i) begin
            if (strobe) begin
               divider_reg <= 8'd0;
               state_reg   <= ST_RUN;
               slot_reg    <= slot_next;
               second_reg  <= second_next;
               carrier_reg <= carrier_next;
               if ((slot_next == 4'd0) && (second_next == 6'd0)) begin
                  snapshot_reg    <= '{year: year_i, month: month_i, day: day_i, dow: dow_i,
                                       hour: hour_i, minute: minute_i, bst: bst_i,
                                       bst_warn: bst_warn_i};
                  frame_start_reg <= 1'b1;
               end
            end else begin
               divider_reg <= divider_reg + 8'd1;
            end
         end
      end
   end

   assign carrier_o     = carrier_reg;
   assign second_o      = second_reg;
   assign frame_start_o = frame_start_reg;

endmodule

// File: tb/tb_msf_frame_encoder.sv
// Self-checking bench for msf_frame_encoder: one instance at TICK_DIV=1 and one at TICK_DIV=3,
// a behavioural frame model feeding a scoreboard queue, a marker vector table and decode checks.
module tb_msf_frame_encoder;

   logic       clk = 1'b0;
   logic       rst_n, tick, en;
   logic [7:0] year;
   logic [4:0] month;
   logic [5:0] day;
   logic [2:0] dow;
   logic [5:0] hour;
   logic [6:0] minute;
   logic       bst, bst_warn;
   logic       car1, fs1, car3, fs3;
   logic [5:0] sec1, sec3;

   always #5 clk = ~clk;

   msf_frame_encoder #(.TICK_DIV(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .enable_i(en),
      .year_i(year), .month_i(month), .day_i(day), .dow_i(dow), .hour_i(hour),
      .minute_i(minute), .bst_i(bst), .bst_warn_i(bst_warn),
      .carrier_o(car1), .second_o(sec1), .frame_start_o(fs1)
   );

   msf_frame_encoder #(.TICK_DIV(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .enable_i(en),
      .year_i(year), .month_i(month), .day_i(day), .dow_i(dow), .hour_i(hour),
      .minute_i(minute), .bst_i(bst), .bst_warn_i(bst_warn),
      .carrier_o(car3), .second_o(sec3), .frame_start_o(fs3)
   );

   typedef struct packed {
      logic [7:0] year;
      logic [4:0] month;
      logic [5:0] day;
      logic [2:0] dow;
      logic [5:0] hour;
      logic [6:0] minute;
      logic       bst;
      logic       warn;
   } snap_t;

   typedef struct {
      logic  run;
      int    div;
      int    slot;
      int    sec;
      snap_t snap;
      logic  carrier;
      logic  fs;
   } mdl_t;

   typedef struct {
      logic c1; int s1; logic f1;
      logic c3; int s3; logic f3;
   } exp_t;

   typedef struct {
      logic tk; logic e; logic c; int s; logic f;
   } vec_t;

   exp_t  exp_q[$];
   mdl_t  m1, m3;
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic snap_t cur_in();
      snap_t s;
      s = '{year: year, month: month, day: day, dow: dow, hour: hour, minute: minute,
            bst: bst, warn: bst_warn};
      return s;
   endfunction

   function automatic logic odd_par(input logic [15:0] v);
      return ($countones(v) % 2) == 0;
   endfunction

   function automatic logic a_of(input int s, input snap_t sn);
      logic [59:0] av;
      logic [7:0]  mk;
      mk = 8'b0111_1110;
      av = '0;
      for (int i = 0; i < 8; i++) av[17 + i] = sn.year[7 - i];
      for (int i = 0; i < 5; i++) av[25 + i] = sn.month[4 - i];
      for (int i = 0; i < 6; i++) av[30 + i] = sn.day[5 - i];
      for (int i = 0; i < 3; i++) av[36 + i] = sn.dow[2 - i];
      for (int i = 0; i < 6; i++) av[39 + i] = sn.hour[5 - i];
      for (int i = 0; i < 7; i++) av[45 + i] = sn.minute[6 - i];
      for (int i = 0; i < 8; i++) av[52 + i] = mk[7 - i];
      return av[s];
   endfunction

   function automatic logic b_of(input int s, input snap_t sn);
      logic [59:0] bv;
      bv     = '0;
      bv[53] = sn.warn;
      bv[54] = odd_par({8'h00, sn.year});
      bv[55] = odd_par({5'h00, sn.month, sn.day});
      bv[56] = odd_par({13'h0000, sn.dow});
      bv[57] = odd_par({3'h0, sn.hour, sn.minute});
      bv[58] = sn.bst;
      return bv[s];
   endfunction

   function automatic logic carrier_of(input int s, input int sl, input snap_t sn);
      if (s == 0) return sl >= 5;
      if (sl == 0) return 1'b0;
      if (sl == 1) return ~a_of(s, sn);
      if (sl == 2) return ~b_of(s, sn);
      return 1'b1;
   endfunction

   function automatic mdl_t mreset();
      mdl_t r;
      r.run = 1'b0; r.div = 0; r.slot = 0; r.sec = 0; r.snap = '0; r.carrier = 1'b1; r.fs = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input logic tk, input logic e, input int tdiv,
                                  input snap_t in);
      mdl_t n;
      n    = m;
      n.fs = 1'b0;
      if (!e) begin
         n.run = 1'b0; n.div = 0; n.slot = 0; n.sec = 0; n.carrier = 1'b1;
      end else if (tk) begin
         if (n.div == tdiv - 1) begin
            n.div = 0;
            if (!n.run) begin
               n.run = 1'b1; n.slot = 0; n.sec = 0;
            end else if (n.slot == 9) begin
               n.slot = 0; n.sec = (n.sec + 1) % 60;
            end else begin
               n.slot++;
            end
            if (n.slot == 0 && n.sec == 0) begin
               n.snap = in; n.fs = 1'b1;
            end
            n.carrier = carrier_of(n.sec, n.slot, n.snap);
         end else begin
            n.div++;
         end
      end
      return n;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle, advance both models, queue the expectation and compare after the edge.
   task automatic clock(input logic tk, input logic e);
      exp_t x;
      tick = tk;
      en   = e;
      m1   = mstep(m1, tk, e, 1, cur_in());
      m3   = mstep(m3, tk, e, 3, cur_in());
      x    = '{c1: m1.carrier, s1: m1.sec, f1: m1.fs, c3: m3.carrier, s3: m3.sec, f3: m3.fs};
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      tick = 1'b0;
      x = exp_q.pop_front();
      check($sformatf("carrier1 s%0d.%0d", m1.sec, m1.slot), car1, x.c1);
      check($sformatf("second1 s%0d.%0d", m1.sec, m1.slot), sec1, x.s1);
      check($sformatf("frame_start1 s%0d.%0d", m1.sec, m1.slot), fs1, x.f1);
      check($sformatf("carrier3 s%0d.%0d", m3.sec, m3.slot), car3, x.c3);
      check($sformatf("second3 s%0d.%0d", m3.sec, m3.slot), sec3, x.s3);
      check($sformatf("frame_start3 s%0d.%0d", m3.sec, m3.slot), fs3, x.f3);
   endtask

   initial begin
      vec_t        tbl[13];
      snap_t       o;
      logic [59:0] rx_a, rx_b;
      logic [7:0]  r8, mk;
      logic        changed;

      // Marker vectors starting from IDLE with enable high.
      tbl[0]  = '{tk: 1'b0, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[1]  = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 0, f: 1'b1};
      tbl[2]  = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 0, f: 1'b0};
      tbl[3]  = '{tk: 1'b0, e: 1'b1, c: 1'b0, s: 0, f: 1'b0};
      tbl[4]  = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 0, f: 1'b0};
      tbl[5]  = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 0, f: 1'b0};
      tbl[6]  = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 0, f: 1'b0};
      tbl[7]  = '{tk: 1'b1, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[8]  = '{tk: 1'b1, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[9]  = '{tk: 1'b1, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[10] = '{tk: 1'b1, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[11] = '{tk: 1'b1, e: 1'b1, c: 1'b1, s: 0, f: 1'b0};
      tbl[12] = '{tk: 1'b1, e: 1'b1, c: 1'b0, s: 1, f: 1'b0};

      mk   = 8'b0111_1110;
      rx_a = '0;
      rx_b = '0;
      year = 8'h23; month = 5'h03; day = 6'h14; dow = 3'd2; hour = 6'h15; minute = 7'h42;
      bst = 1'b1; bst_warn = 1'b1;
      o = cur_in();

      // Reset held with ticks and enable active.
      rst_n = 1'b0; en = 1'b1; tick = 1'b0;
      m1 = mreset(); m3 = mreset();
      for (int i = 0; i < 6; i++) begin
         tick = i[0];
         @(posedge clk);
         #1;
         check("reset carrier1", car1, 1);
         check("reset second1", sec1, 0);
         check("reset frame_start1", fs1, 0);
         check("reset carrier3", car3, 1);
      end
      tick = 1'b0;
      rst_n = 1'b1;
      clock(1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         clock(tbl[i].tk, tbl[i].e);
         $display("vec %0d: tick=%0b en=%0b carrier=%0b second=%0d frame_start=%0b",
                  i, tbl[i].tk, tbl[i].e, car1, sec1, fs1);
         check($sformatf("vec%0d carrier", i), car1, tbl[i].c);
         check($sformatf("vec%0d second", i), sec1, tbl[i].s);
         check($sformatf("vec%0d frame_start", i), fs1, tbl[i].f);
      end

      // Rest of frame 1; inputs change at second 20 and must not leak into it.
      changed = 1'b0;
      for (int k = 0; k < 700 && !(m1.sec == 59 && m1.slot == 9); k++) begin
         if (!changed && m1.sec == 20) begin
            year = 8'h24; minute = 7'h43; bst = 1'b0; bst_warn = 1'b0; day = 6'h15;
            changed = 1'b1;
         end
         clock(1'b1, 1'b1);
         if (m1.slot == 1) rx_a[m1.sec] = ~car1;
         if (m1.slot == 2) rx_b[m1.sec] = ~car1;
      end
      check("frame1 reached s59.9", sec1, 59);

      for (int i = 0; i < 8; i++) r8[7 - i] = rx_a[17 + i];
      check("dec year", r8, o.year);
      for (int i = 0; i < 5; i++) r8[4 - i] = rx_a[25 + i];
      check("dec month", r8[4:0], o.month);
      for (int i = 0; i < 6; i++) r8[5 - i] = rx_a[30 + i];
      check("dec day", r8[5:0], o.day);
      for (int i = 0; i < 3; i++) r8[2 - i] = rx_a[36 + i];
      check("dec dow", r8[2:0], o.dow);
      for (int i = 0; i < 6; i++) r8[5 - i] = rx_a[39 + i];
      check("dec hour", r8[5:0], o.hour);
      for (int i = 0; i < 7; i++) r8[6 - i] = rx_a[45 + i];
      check("dec minute", r8[6:0], o.minute);
      for (int i = 0; i < 8; i++) r8[7 - i] = rx_a[52 + i];
      check("A52-59", r8, mk);
      check("A1-16", rx_a[16:1], 0);
      check("B1-52", rx_b[52:1], 0);
      check("B53 warn", rx_b[53], o.warn);
      check("B54 par", rx_b[54], odd_par({8'h00, o.year}));
      check("B55 par", rx_b[55], odd_par({5'h00, o.month, o.day}));
      check("B56 par", rx_b[56], odd_par({13'h0000, o.dow}));
      check("B57 par", rx_b[57], odd_par({3'h0, o.hour, o.minute}));
      check("B58 bst", rx_b[58], o.bst);
      check("B59", rx_b[59], 0);

      // Wrap into frame 2 with the changed inputs.
      clock(1'b1, 1'b1);
      check("wrap second", sec1, 0);
      check("wrap frame_start", fs1, 1);
      check("wrap carrier", car1, 0);

      for (int k = 0; k < 700 && !(m1.sec == 30 && m1.slot == 2); k++) clock(1'b1, 1'b1);
      check("frame2 reached s30", sec1, 30);

      // Abort with a coincident strobe, then restart.
      clock(1'b1, 1'b0);
      check("abort carrier", car1, 1);
      check("abort second", sec1, 0);
      clock(1'b0, 1'b1);
      check("idle carrier", car1, 1);
      clock(1'b1, 1'b1);
      check("restart frame_start", fs1, 1);
      check("restart carrier", car1, 0);
      check("restart second", sec1, 0);

      // TICK_DIV=3 instance from a fresh IDLE.
      clock(1'b0, 1'b0);
      for (int t = 1; t <= 40; t++) begin
         clock(1'b1, 1'b1);
         if (t < 3) begin
            check($sformatf("div3 idle carrier t%0d", t), car3, 1);
            check($sformatf("div3 idle fs t%0d", t), fs3, 0);
         end
         if (t == 3) check("div3 frame_start t3", fs3, 1);
         if (t == 4) check("div3 frame_start t4", fs3, 0);
         if (t == 17) check("div3 carrier t17", car3, 0);
         if (t == 18) check("div3 carrier t18", car3, 1);
         if (t == 32) check("div3 second t32", sec3, 0);
         if (t == 33) check("div3 second t33", sec3, 1);
      end

      // Asynchronous reset mid-frame.
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset carrier1", car1, 1);
      check("async reset second1", sec1, 0);
      check("async reset second3", sec3, 0);
      m1 = mreset(); m3 = mreset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clock(1'b0, 1'b1);
      check("scoreboard drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
